silencer_feeder: RTL

//  Transmit side of the silencer input stream: on each UPDATE pulse, reads DEPTH per-transducer
//  {intensity, phase} words from the drive RAM, scales intensity by a latched modulation value,
//  and emits one contiguous DEPTH-cycle DOUT_VALID burst into silencer DIN_VALID/INTENSITY_IN/PHASE_IN.

---
 rtl/silencer_feeder_pkg.sv | 18 +
 rtl/silencer_feeder_if.sv | 33 +++
 rtl/feeder_intensity_mod.sv | 42 ++++
 rtl/silencer_feeder.sv | 112 +++++++++++
 4 files changed

// File: rtl/silencer_feeder_pkg.sv
// Shared definitions for the silencer feeder.
//   FEEDER_RAM_DATA_WIDTH : drive RAM word width, {intensity, phase}
//   FEEDER_INTENSITY_MSB  : top bit of the intensity byte in a RAM word
//   FEEDER_PHASE_MSB      : top bit of the phase byte in a RAM word
//   feeder_state_t        : burst sequencer states
package silencer_feeder_pkg;

  localparam int unsigned FEEDER_RAM_DATA_WIDTH = 16;
  localparam int unsigned FEEDER_INTENSITY_MSB  = 15;
  localparam int unsigned FEEDER_PHASE_MSB      = 7;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } feeder_state_t;

endpackage

// File: rtl/silencer_feeder_if.sv
// Handshake/data bundle between the feeder, its drive RAM and the silencer.
//   update        : one-cycle burst request
//   mod_value     : intensity modulation factor, sampled with update
//   ram_addr      : drive RAM read address
//   ram_data      : drive RAM read data (1-cycle latency)
//   intensity_out : scaled intensity to silencer
//   phase_out     : phase to silencer
//   dout_valid    : output word valid
//   busy          : burst in progress
// master = requester/RAM side, slave = feeder.
interface silencer_feeder_if;
  import silencer_feeder_pkg::*;

  logic                             update;
  logic [7:0]                       mod_value;
  logic [7:0]                       ram_addr;
  logic [FEEDER_RAM_DATA_WIDTH-1:0] ram_data;
  logic [7:0]                       intensity_out;
  logic [7:0]                       phase_out;
  logic                             dout_valid;
  logic                             busy;

  modport master (
    output update, mod_value, ram_data,
    input  ram_addr, intensity_out, phase_out, dout_valid, busy
  );

  modport slave (
    input  update, mod_value, ram_data,
    output ram_addr, intensity_out, phase_out, dout_valid, busy
  );

endinterface

// File: rtl/feeder_intensity_mod.sv
// Registered intensity scaler: intensity_o = (intensity_i * (mod_i + 1)) >> 8.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   valid_i       : input word valid; output register only loads when set
//   intensity_i   : raw intensity
//   mod_i         : modulation factor (255 = identity, 0 = silence)
//   valid_o       : valid_i delayed one cycle
//   intensity_o   : scaled intensity, held while valid_o is low
module feeder_intensity_mod (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  input  logic [7:0] intensity_i,
  input  logic [7:0] mod_i,
  output logic       valid_o,
  output logic [7:0] intensity_o
);

  logic [16:0] product;
  logic        valid_q;
  logic [7:0]  intensity_q;

  // 8x9-bit product; mod+1 makes 255 an exact identity
  always_comb begin
    product = 17'(intensity_i) * (17'(mod_i) + 17'd1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q     <= 1'b0;
      intensity_q <= 8'd0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        intensity_q <= 8'(product >> 8);
      end
    end
  end

  assign valid_o     = valid_q;
  assign intensity_o = intensity_q;

endmodule

// File: rtl/silencer_feeder.sv
// Silencer feeder: on an accepted update, reads DEPTH {intensity, phase} words from the drive
// RAM, scales intensity by the mod value latched at acceptance and emits one contiguous
// DEPTH-cycle dout_valid burst.
//   clk_i         : system clock
//   rst_i         : synchronous active-high reset
//   bus_io        : silencer_feeder_if slave (update/mod in, RAM port, silencer outputs, busy)
//   overrun_cnt_o : saturating count of updates dropped while busy
//                   (only when FEEDER_OVERRUN_CNT_EN is defined)
module silencer_feeder
  import silencer_feeder_pkg::*;
#(
  parameter int unsigned DEPTH = 249
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  silencer_feeder_if.slave      bus_io
`ifdef FEEDER_OVERRUN_CNT_EN
  ,
  output logic [15:0]           overrun_cnt_o
`endif
);

  localparam logic [7:0] LastAddr = 8'(DEPTH - 1);

  feeder_state_t state_q, state_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    mod_q, mod_d;
  logic          rd_vld_q;  // RAM data for an issued address is present this cycle
  logic [7:0]    phase_q;
  logic          mod_valid;
  logic [7:0]    mod_intensity;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    mod_d   = mod_q;
    unique case (state_q)
      IDLE: begin
        addr_d = 8'd0;
        if (bus_io.update) begin
          state_d = READ;
          mod_d   = bus_io.mod_value;
        end
      end
      READ: begin
        if (addr_q == LastAddr) begin
          state_d = DRAIN;
          addr_d  = 8'd0;
        end else begin
          addr_d = addr_q + 8'd1;
        end
      end
      DRAIN: begin
        // Last read data has entered the scaler; it leaves the output this cycle
        if (!rd_vld_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      addr_q   <= 8'd0;
      mod_q    <= 8'd0;
      rd_vld_q <= 1'b0;
      phase_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      mod_q    <= mod_d;
      rd_vld_q <= (state_q == READ);
      // Matches the scaler's register stage so phase and intensity stay aligned
      if (rd_vld_q) begin
        phase_q <= bus_io.ram_data[FEEDER_PHASE_MSB:0];
      end
    end
  end

  feeder_intensity_mod u_intensity_mod (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (rd_vld_q),
    .intensity_i (bus_io.ram_data[FEEDER_INTENSITY_MSB -: 8]),
    .mod_i       (mod_q),
    .valid_o     (mod_valid),
    .intensity_o (mod_intensity)
  );

  assign bus_io.ram_addr      = addr_q;
  assign bus_io.busy          = (state_q != IDLE);
  assign bus_io.dout_valid    = mod_valid;
  assign bus_io.intensity_out = mod_intensity;
  assign bus_io.phase_out     = phase_q;

`ifdef FEEDER_OVERRUN_CNT_EN
  logic [15:0] overrun_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overrun_q <= 16'd0;
    end else if (bus_io.update && (state_q != IDLE) && (overrun_q != 16'hFFFF)) begin
      overrun_q <= overrun_q + 16'd1;
    end
  end

  assign overrun_cnt_o = overrun_q;
`endif

endmodule
